// File: rtl/port_uart_tx_pkg.sv
// port_uart_tx shared types and constants.
// FSM encoding, ASCII offsets and the nibble-to-hex encoder.
package port_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASC_DIGIT = 8'h30;
  localparam logic [7:0] ASC_ALPHA = 8'h37;
  localparam int         DATA_BITS = 8;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9) return {4'h0, n} + ASC_DIGIT;
    return {4'h0, n} + ASC_ALPHA;
  endfunction

endpackage

// File: rtl/port_uart_tx_sync_fifo.sv
// Small synchronous FIFO for queued port nibbles.
// Push while full is accepted only together with a pop.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push & (~full | pop);
  assign rd_en   = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed, pointers guard validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/port_uart_tx.sv
// Port-change logger: queues nibble changes, sends them
// as ASCII hex characters on an 8N1 UART line.
module port_uart_tx
  import port_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  in_port,
  input  logic                        in_enable,
  input  logic                        in_overflow_clr,
  output logic                        out_tx,
  output logic                        out_busy,
  output logic                        out_overflow,
  output logic [$clog2(FIFO_DEPTH):0] out_fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [3:0]    prev_q;
  logic          change;
  logic          push;
  logic          pop;
  logic          drop;
  logic          last;
  logic [3:0]    rd_data;
  logic          full;
  logic          empty;

  assign change = (in_port != prev_q);
  assign push   = change & in_enable;
  assign drop   = push & full & ~pop;
  assign last   = (baud_q == BW'(CLKS_PER_BIT - 1));

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_port),
    .rd_data (rd_data),
    .count   (out_fifo_count),
    .full    (full),
    .empty   (empty)
  );

  // Track last port value and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q       <= 4'h0;
      out_overflow <= 1'b0;
    end else begin
      prev_q <= in_port;
      if (drop)                 out_overflow <= 1'b1;
      else if (in_overflow_clr) out_overflow <= 1'b0;
    end
  end

  // Transmit FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state, next line level and FIFO pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = hex_ascii(rd_data);
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          baud_d  = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (last) begin
          baud_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (last) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            shift_d = hex_ascii(rd_data);
            bit_d   = '0;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
    endcase
  end

  assign out_tx   = tx_q;
  assign out_busy = (state_q != IDLE) | (out_fifo_count != '0);

endmodule
